// File: rtl/aes_inv_key_expand_pkg.sv
// Shared AES key-schedule types, constants and byte/word helpers.
// The S-box is packed as one vector with byte 0x00's image in the MSBs.
package aes_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  localparam int         NUM_ROUNDS_128 = 10;
  localparam logic [7:0] RCON_FIRST     = 8'h01;
  localparam logic [7:0] RCON_LAST      = 8'h36;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry n sits at bit offset (255-n)*8, and 255-n == ~n for a byte.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Only ever applied to the Rcon sequence, where 0x1b is the one wrap point.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return (b == 8'h1b) ? 8'h80 : {1'b0, b[7:1]};
  endfunction

endpackage

// File: rtl/aes_inv_key_expand_if.sv
// Key-in / round-key-out handshake bundle of the key schedule.
// Optional AES_KEXP_FWD_EN adds the dir_i direction select.
interface aes_inv_key_expand_if;
  logic         key_valid_i;
  logic         key_ready_o;
  logic [127:0] key_i;
  logic         rk_valid_o;
  logic         rk_ready_i;
  logic [127:0] rk_o;
  logic [3:0]   rk_round_o;
  logic         rk_last_o;
`ifdef AES_KEXP_FWD_EN
  logic         dir_i;
`endif

  modport master (
`ifdef AES_KEXP_FWD_EN
    output dir_i,
`endif
    output key_valid_i, key_i, rk_ready_i,
    input  key_ready_o, rk_valid_o, rk_o, rk_round_o, rk_last_o
  );

  modport slave (
`ifdef AES_KEXP_FWD_EN
    input  dir_i,
`endif
    input  key_valid_i, key_i, rk_ready_i,
    output key_ready_o, rk_valid_o, rk_o, rk_round_o, rk_last_o
  );
endinterface

// File: rtl/aes_inv_key_expand_sub_word.sv
// Combinational SubWord: forward S-box applied to each byte of a word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] subst
);
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign subst[8*b +: 8] = sbox(word[8*b +: 8]);
  end
endmodule

// File: rtl/aes_inv_key_expand.sv
// Iterative AES-128 key schedule streaming round keys 10..0 (or 0..10 when
// built with AES_KEXP_FWD_EN and dir_i=1), one per rk handshake.
module aes_inv_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_128
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  aes_inv_key_expand_if.slave  kx
);
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  if (NUM_ROUNDS != NUM_ROUNDS_128) begin : g_bad_rounds
    $error("aes_inv_key_expand supports AES-128 only (NUM_ROUNDS=10)");
  end

  state_e       state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [31:0]  w0, w1, w2, w3, iw3, sub_in, sub_out;
  logic [127:0] rk_next;
  logic         end_rnd;

  assign {w0, w1, w2, w3} = rk_q;
  assign iw3 = w3 ^ w2;

`ifdef AES_KEXP_FWD_EN
  logic        dir_q, dir_d;
  logic [31:0] fw0, fw1, fw2;

  // One S-box bank: forward rotates the old w3, inverse the recovered w3.
  assign sub_in  = dir_q ? rot_word(w3) : rot_word(iw3);
  assign fw0     = w0 ^ sub_out ^ {rcon_q, 24'h0};
  assign fw1     = w1 ^ fw0;
  assign fw2     = w2 ^ fw1;
  assign rk_next = dir_q ? {fw0, fw1, fw2, w3 ^ fw2}
                         : {w0 ^ sub_out ^ {rcon_q, 24'h0}, w1 ^ w0, w2 ^ w1, iw3};
  assign end_rnd = dir_q ? (round_q == LAST_RND) : (round_q == 4'd0);
`else
  assign sub_in  = rot_word(iw3);
  assign rk_next = {w0 ^ sub_out ^ {rcon_q, 24'h0}, w1 ^ w0, w2 ^ w1, iw3};
  assign end_rnd = (round_q == 4'd0);
`endif

  aes_sub_word u_sub_word (.word(sub_in), .subst(sub_out));

  assign kx.key_ready_o = rst_ni && (state_q == IDLE) && !clear_i;
  assign kx.rk_valid_o  = (state_q == RUN);
  assign kx.rk_o        = rk_q;
  assign kx.rk_round_o  = round_q;
  assign kx.rk_last_o   = kx.rk_valid_o && end_rnd;

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    rcon_d  = rcon_q;
`ifdef AES_KEXP_FWD_EN
    dir_d   = dir_q;
`endif
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (kx.key_valid_i) begin
          state_d = RUN;
          rk_d    = kx.key_i;
`ifdef AES_KEXP_FWD_EN
          dir_d   = kx.dir_i;
          round_d = kx.dir_i ? 4'd0 : LAST_RND;
          rcon_d  = kx.dir_i ? RCON_FIRST : RCON_LAST;
`else
          round_d = LAST_RND;
          rcon_d  = RCON_LAST;
`endif
        end
        RUN: if (kx.rk_ready_i) begin
          if (end_rnd) begin
            state_d = IDLE;
          end else begin
            rk_d = rk_next;
`ifdef AES_KEXP_FWD_EN
            round_d = dir_q ? round_q + 4'd1 : round_q - 4'd1;
            rcon_d  = dir_q ? xtime(rcon_q) : inv_xtime(rcon_q);
`else
            round_d = round_q - 4'd1;
            rcon_d  = inv_xtime(rcon_q);
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rk_q    <= '0;
      round_q <= '0;
      rcon_q  <= RCON_LAST;
`ifdef AES_KEXP_FWD_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
`ifdef AES_KEXP_FWD_EN
      dir_q   <= dir_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_inv_key_expand.sv
// Directed bench for aes_inv_key_expand using the FIPS-197 A.1 key schedule.
// Inputs change just after negedge; outputs are checked at negedge.
module tb_aes_inv_key_expand;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  int   checks = 0;
  int   fails  = 0;
  logic [127:0] exp_rk [0:10];

  always #5 clk = ~clk;

  aes_inv_key_expand_if kx();

  aes_inv_key_expand dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .kx      (kx)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a key for one cycle; returns at the negedge where the first key shows.
  task automatic load_key(input logic [127:0] key, input logic dir);
    kx.key_valid_i = 1'b1;
    kx.key_i       = key;
`ifdef AES_KEXP_FWD_EN
    kx.dir_i       = dir;
`else
    if (dir) $display("note: forward direction not built");
`endif
    @(negedge clk);
    kx.key_valid_i = 1'b0;
  endtask

  initial begin
    int  cur;
    int  budget;
    bit  done;

    exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    kx.key_valid_i = 1'b0;
    kx.key_i       = '0;
    kx.rk_ready_i  = 1'b0;
`ifdef AES_KEXP_FWD_EN
    kx.dir_i       = 1'b0;
`endif

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(kx.rk_valid_o), 128'd0);
    chk("rst_rk", kx.rk_o, 128'd0);
    chk("rst_round", 128'(kx.rk_round_o), 128'd0);
    chk("rst_last", 128'(kx.rk_last_o), 128'd0);
    chk("rst_kready", 128'(kx.key_ready_o), 128'd0);
    rst_n = 1'b1;
    #1 chk("post_rst_kready", 128'(kx.key_ready_o), 128'd1);

    // Full inverse schedule at full throughput
    @(negedge clk);
    kx.rk_ready_i = 1'b1;
    load_key(exp_rk[10], 1'b0);
    for (int r = 10; r >= 0; r--) begin
      chk($sformatf("seq_valid_r%0d", r), 128'(kx.rk_valid_o), 128'd1);
      chk($sformatf("seq_rk_r%0d", r), kx.rk_o, exp_rk[r]);
      chk($sformatf("seq_round_r%0d", r), 128'(kx.rk_round_o), 128'(r));
      chk($sformatf("seq_last_r%0d", r), 128'(kx.rk_last_o), 128'(r == 0));
      chk($sformatf("seq_kready_r%0d", r), 128'(kx.key_ready_o), 128'd0);
      @(negedge clk);
    end
    chk("seq_end_valid", 128'(kx.rk_valid_o), 128'd0);
    chk("seq_end_kready", 128'(kx.key_ready_o), 128'd1);

    // Random backpressure: values must only advance on handshakes
    kx.rk_ready_i = 1'b0;
    load_key(exp_rk[10], 1'b0);
    cur = 10; budget = 0; done = 0;
    while (!done && budget < 300) begin
      chk("bp_valid", 128'(kx.rk_valid_o), 128'd1);
      chk($sformatf("bp_rk_r%0d", cur), kx.rk_o, exp_rk[cur]);
      chk($sformatf("bp_round_r%0d", cur), 128'(kx.rk_round_o), 128'(cur));
      kx.rk_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (kx.rk_ready_i) begin
        if (cur == 0) done = 1;
        else cur--;
      end
      budget++;
    end
    chk("bp_completed", 128'(done), 128'd1);
    chk("bp_end_valid", 128'(kx.rk_valid_o), 128'd0);

    // Abort at round 6, then clear blocks a coincident key, then restart
    kx.rk_ready_i = 1'b1;
    @(negedge clk);
    load_key(exp_rk[10], 1'b0);
    repeat (4) @(negedge clk);
    chk("abort_round6", 128'(kx.rk_round_o), 128'd6);
    clear = 1'b1;
    @(negedge clk);
    chk("abort_valid", 128'(kx.rk_valid_o), 128'd0);
    chk("abort_rk_kept", kx.rk_o, exp_rk[6]);
    chk("abort_kready_clr", 128'(kx.key_ready_o), 128'd0);
    clear = 1'b0;
    #1 chk("abort_kready", 128'(kx.key_ready_o), 128'd1);
    kx.key_valid_i = 1'b1;
    kx.key_i       = exp_rk[10];
    clear          = 1'b1;
    @(negedge clk);
    chk("clr_blocks_key", 128'(kx.rk_valid_o), 128'd0);
    clear = 1'b0;
    @(negedge clk);
    kx.key_valid_i = 1'b0;
    chk("restart_valid", 128'(kx.rk_valid_o), 128'd1);
    chk("restart_round", 128'(kx.rk_round_o), 128'd10);
    @(negedge clk);
    chk("restart_rk9", kx.rk_o, exp_rk[9]);
    chk("restart_round9", 128'(kx.rk_round_o), 128'd9);
    repeat (10) @(negedge clk);
    chk("restart_end_valid", 128'(kx.rk_valid_o), 128'd0);

    // Async reset at round 4
    load_key(exp_rk[10], 1'b0);
    repeat (6) @(negedge clk);
    chk("ar_round4", 128'(kx.rk_round_o), 128'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 128'(kx.rk_valid_o), 128'd0);
    chk("ar_rk", kx.rk_o, 128'd0);
    chk("ar_round", 128'(kx.rk_round_o), 128'd0);
    chk("ar_last", 128'(kx.rk_last_o), 128'd0);
    chk("ar_kready", 128'(kx.key_ready_o), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ar_kready_rel", 128'(kx.key_ready_o), 128'd1);

    // Back-to-back: key held valid through RUN
    @(negedge clk);
    kx.key_valid_i = 1'b1;
    kx.key_i       = exp_rk[10];
    @(negedge clk);
    for (int r = 10; r >= 0; r--) begin
      chk($sformatf("b2b_round_r%0d", r), 128'(kx.rk_round_o), 128'(r));
      chk($sformatf("b2b_kready_r%0d", r), 128'(kx.key_ready_o), 128'd0);
      @(negedge clk);
    end
    chk("b2b_gap_valid", 128'(kx.rk_valid_o), 128'd0);
    chk("b2b_gap_kready", 128'(kx.key_ready_o), 128'd1);
    @(negedge clk);
    kx.key_valid_i = 1'b0;
    chk("b2b_second_valid", 128'(kx.rk_valid_o), 128'd1);
    chk("b2b_second_round", 128'(kx.rk_round_o), 128'd10);
    chk("b2b_second_rk", kx.rk_o, exp_rk[10]);
    repeat (11) @(negedge clk);
    chk("b2b_end_valid", 128'(kx.rk_valid_o), 128'd0);

`ifdef AES_KEXP_FWD_EN
    // Forward expansion from the cipher key
    load_key(exp_rk[0], 1'b1);
    for (int r = 0; r <= 10; r++) begin
      chk($sformatf("fwd_rk_r%0d", r), kx.rk_o, exp_rk[r]);
      chk($sformatf("fwd_round_r%0d", r), 128'(kx.rk_round_o), 128'(r));
      chk($sformatf("fwd_last_r%0d", r), 128'(kx.rk_last_o), 128'(r == 10));
      @(negedge clk);
    end
    chk("fwd_end_valid", 128'(kx.rk_valid_o), 128'd0);
    kx.dir_i = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
